// File: rtl/wash_pkg.sv
// Shared phase codes, duration table and status layout for the wash sequencer.
// Combinational definitions only; no latency.
// No flow control of its own.
package wash_pkg;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_FILL   = 3'd1,
        PH_WASH   = 3'd2,
        PH_DRAIN  = 3'd3,
        PH_RINSE  = 3'd4,
        PH_SPIN   = 3'd5,
        PH_DONE   = 3'd6,
        PH_PAUSED = 3'd7
    } phase_e;

    typedef enum logic [1:0] {
        PROG_QUICK  = 2'd0,
        PROG_NORMAL = 2'd1,
        PROG_HEAVY  = 2'd2,
        PROG_ALT    = 2'd3
    } prog_e;

    // Timed-phase durations in ticks, ordered FILL, WASH, DRAIN, RINSE, SPIN.
    localparam logic [0:4][7:0] DUR_QUICK  = {8'd10, 8'd30,  8'd10, 8'd15, 8'd20};
    localparam logic [0:4][7:0] DUR_NORMAL = {8'd20, 8'd60,  8'd15, 8'd30, 8'd40};
    localparam logic [0:4][7:0] DUR_HEAVY  = {8'd30, 8'd120, 8'd20, 8'd45, 8'd90};

    localparam int unsigned ST_BUSY       = 7;
    localparam int unsigned ST_PAUSED     = 6;
    localparam int unsigned ST_DONE       = 5;
    localparam int unsigned ST_DOOR_FAULT = 4;
    localparam int unsigned ST_PROG_MSB   = 3;
    localparam int unsigned ST_PROG_LSB   = 2;

    typedef struct packed {
        logic       busy;
        logic       paused;
        logic       done;
        logic       door_fault;
        logic [1:0] prog;
        logic [1:0] rsvd;
    } status_t;

    function automatic logic [2:0] next_phase(input logic [2:0] ph);
        logic [2:0] nxt;
        case (ph)
            PH_FILL:  nxt = PH_WASH;
            PH_WASH:  nxt = PH_DRAIN;
            PH_DRAIN: nxt = PH_RINSE;
            PH_RINSE: nxt = PH_SPIN;
            PH_SPIN:  nxt = PH_DONE;
            default:  nxt = PH_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/wash_dur_rom.sv
// Duration lookup: program x phase -> ticks. Program 3 aliases normal.
// Purely combinational, zero latency.
// No flow control.
module wash_dur_rom
    import wash_pkg::*;
#(
    parameter int unsigned DONE_HOLD = 5
) (
    input  logic [1:0] prog,
    input  logic [2:0] phase,
    output logic [7:0] dur
);

    logic [0:4][7:0] row;

    always_comb begin
        case (prog)
            PROG_QUICK: row = DUR_QUICK;
            PROG_HEAVY: row = DUR_HEAVY;
            default:    row = DUR_NORMAL;
        endcase
    end

    always_comb begin
        dur = 8'd0;
        case (phase)
            PH_FILL:  dur = row[0];
            PH_WASH:  dur = row[1];
            PH_DRAIN: dur = row[2];
            PH_RINSE: dur = row[3];
            PH_SPIN:  dur = row[4];
            PH_DONE:  dur = DONE_HOLD[7:0];
            default:  dur = 8'd0;
        endcase
    end

endmodule

// File: rtl/wash_program_sequencer.sv
// Wash program FSM: steps FILL..SPIN, DONE, IDLE, issuing one command per phase.
// New phase command appears the cycle after the expiring tick; countdown starts after handshake.
// Holds ctrl/cmd_dur while cmd_valid && !cmd_ready; pause is the only offer withdrawal.
module wash_program_sequencer
    import wash_pkg::*;
#(
    parameter int unsigned DONE_HOLD = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] prog_sel,
    input  logic       door_closed,
    input  logic       pause_req,
    input  logic       tick,
    input  logic       cmd_ready,
    output logic [2:0] ctrl,
    output logic [7:0] cmd_dur,
    output logic       cmd_valid,
    output logic [7:0] remaining,
    output logic [7:0] status
);

    localparam logic [2:0] S_IDLE   = PH_IDLE;
    localparam logic [2:0] S_FILL   = PH_FILL;
    localparam logic [2:0] S_DONE   = PH_DONE;
    localparam logic [2:0] S_PAUSED = PH_PAUSED;

    logic [2:0] state;
    logic [2:0] saved_phase;
    logic [7:0] remaining_q;
    logic [7:0] cmd_dur_q;
    logic       cmd_valid_q;
    logic [1:0] prog_q;
    logic       door_fault_q;
    logic       done_q;

    logic [1:0] rom_prog;
    logic [2:0] rom_phase;
    logic [7:0] rom_dur;
    logic       hold_req;
    status_t    st;

    // One lookup serves both program start (from prog_sel) and phase advance.
    assign rom_prog  = (state == S_IDLE) ? prog_sel : prog_q;
    assign rom_phase = (state == S_IDLE) ? S_FILL : next_phase(state);

    wash_dur_rom #(
        .DONE_HOLD (DONE_HOLD)
    ) u_rom (
        .prog  (rom_prog),
        .phase (rom_phase),
        .dur   (rom_dur)
    );

    assign hold_req = !door_closed || pause_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            saved_phase  <= S_IDLE;
            remaining_q  <= 8'd0;
            cmd_dur_q    <= 8'd0;
            cmd_valid_q  <= 1'b0;
            prog_q       <= 2'd0;
            door_fault_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (door_closed) begin
                            prog_q       <= prog_sel;
                            door_fault_q <= 1'b0;
                            state        <= S_FILL;
                            remaining_q  <= rom_dur;
                            cmd_dur_q    <= rom_dur;
                            cmd_valid_q  <= 1'b1;
                        end else begin
                            door_fault_q <= 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    // Resume reissues the command with the frozen count, no reload.
                    if (door_closed && !pause_req) begin
                        state       <= saved_phase;
                        cmd_dur_q   <= remaining_q;
                        cmd_valid_q <= 1'b1;
                    end
                end
                default: begin
                    if (state != S_DONE && hold_req) begin
                        saved_phase <= state;
                        state       <= S_PAUSED;
                        cmd_valid_q <= 1'b0;
                    end else if (cmd_valid_q) begin
                        if (cmd_ready) begin
                            cmd_valid_q <= 1'b0;
                        end
                    end else if (tick) begin
                        if (remaining_q == 8'd1) begin
                            if (state == S_DONE) begin
                                state       <= S_IDLE;
                                remaining_q <= 8'd0;
                                cmd_dur_q   <= 8'd0;
                                done_q      <= 1'b1;
                            end else begin
                                state       <= next_phase(state);
                                remaining_q <= rom_dur;
                                cmd_dur_q   <= rom_dur;
                                cmd_valid_q <= 1'b1;
                            end
                        end else begin
                            remaining_q <= remaining_q - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        st            = '0;
        st.busy       = (state != S_IDLE);
        st.paused     = (state == S_PAUSED);
        st.done       = done_q;
        st.door_fault = door_fault_q;
        st.prog       = prog_q;
        st.rsvd       = 2'b00;
    end

    assign ctrl      = state;
    assign cmd_dur   = cmd_dur_q;
    assign cmd_valid = cmd_valid_q;
    assign remaining = remaining_q;
    assign status    = st;

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Directed bench for wash_program_sequencer with hand-computed expectations.
module tb_wash_program_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] prog_sel;
    logic       door_closed;
    logic       pause_req;
    logic       tick;
    logic       cmd_ready;
    logic [2:0] ctrl;
    logic [7:0] cmd_dur;
    logic       cmd_valid;
    logic [7:0] remaining;
    logic [7:0] status;

    int vecs = 0;
    int errs = 0;

    wash_program_sequencer #(.DONE_HOLD(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_sel    (prog_sel),
        .door_closed (door_closed),
        .pause_req   (pause_req),
        .tick        (tick),
        .cmd_ready   (cmd_ready),
        .ctrl        (ctrl),
        .cmd_dur     (cmd_dur),
        .cmd_valid   (cmd_valid),
        .remaining   (remaining),
        .status      (status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"},   {5'd0, ctrl}, 8'd0);
        chk({tag, "_dur"},    cmd_dur, 8'd0);
        chk({tag, "_valid"},  {7'd0, cmd_valid}, 8'd0);
        chk({tag, "_rem"},    remaining, 8'd0);
        chk({tag, "_status"}, status, 8'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int q_dur [6];
        q_dur = '{10, 30, 10, 15, 20, 5};
        rst = 1'b0; start = 1'b0; prog_sel = 2'd0; door_closed = 1'b1;
        pause_req = 1'b0; tick = 1'b0; cmd_ready = 1'b1;
        #12;
        chk_zero("reset");
        rst = 1'b1;
        step();

        // Quick program end to end with cmd_ready held high.
        prog_sel = 2'd0; start = 1'b1; step(); start = 1'b0;
        chk("quick_status", status, 8'h80);
        for (int p = 0; p < 6; p++) begin
            chk($sformatf("quick_ctrl%0d", p + 1), {5'd0, ctrl}, 8'(p + 1));
            chk($sformatf("quick_dur%0d", p + 1), cmd_dur, 8'(q_dur[p]));
            chk($sformatf("quick_vld%0d", p + 1), {7'd0, cmd_valid}, 8'd1);
            step();
            chk($sformatf("quick_hs%0d", p + 1), {7'd0, cmd_valid}, 8'd0);
            adv(q_dur[p]);
        end
        chk("quick_end_ctrl", {5'd0, ctrl}, 8'd0);
        chk("quick_end_rem", remaining, 8'd0);
        chk("quick_done_pulse", status, 8'h20);
        step();
        chk("quick_done_clear", status, 8'h00);

        // Normal program with backpressure: ticks ignored while the offer waits.
        prog_sel = 2'd1; cmd_ready = 1'b0; start = 1'b1; step(); start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick = 1'b1;
            step();
            chk("bp_rem", remaining, 8'd20);
            chk("bp_ctrl", {5'd0, ctrl}, 8'd1);
            chk("bp_dur", cmd_dur, 8'd20);
            chk("bp_vld", {7'd0, cmd_valid}, 8'd1);
        end
        tick = 1'b0; cmd_ready = 1'b1; step();
        chk("bp_hs", {7'd0, cmd_valid}, 8'd0);
        adv(1);
        chk("bp_count", remaining, 8'd19);
        chk("bp_status", status, 8'h84);

        // Door opened in WASH at remaining=17.
        adv(19);
        chk("wash_ctrl", {5'd0, ctrl}, 8'd2);
        chk("wash_dur", cmd_dur, 8'd60);
        step();
        adv(43);
        chk("wash_rem17", remaining, 8'd17);
        door_closed = 1'b0; step();
        chk("door_ctrl", {5'd0, ctrl}, 8'd7);
        chk("door_status", status, 8'hC4);
        chk("door_vld", {7'd0, cmd_valid}, 8'd0);
        adv(3);
        chk("door_frozen", remaining, 8'd17);
        chk("door_still", {5'd0, ctrl}, 8'd7);
        door_closed = 1'b1; step();
        chk("resume_ctrl", {5'd0, ctrl}, 8'd2);
        chk("resume_dur", cmd_dur, 8'd17);
        chk("resume_vld", {7'd0, cmd_valid}, 8'd1);

        // Pause request withdraws a pending offer.
        cmd_ready = 1'b0; pause_req = 1'b1; step();
        chk("pause_ctrl", {5'd0, ctrl}, 8'd7);
        chk("pause_vld", {7'd0, cmd_valid}, 8'd0);
        pause_req = 1'b0; step();
        chk("unpause_ctrl", {5'd0, ctrl}, 8'd2);
        chk("unpause_dur", cmd_dur, 8'd17);
        cmd_ready = 1'b1;
        do_reset();

        // Start with door open latches a sticky fault.
        door_closed = 1'b0; start = 1'b1; step(); start = 1'b0;
        chk("fault_status", status, 8'h10);
        chk("fault_ctrl", {5'd0, ctrl}, 8'd0);
        step();
        chk("fault_sticky", status, 8'h10);
        door_closed = 1'b1; prog_sel = 2'd0; start = 1'b1; step(); start = 1'b0;
        chk("fault_clear", status, 8'h80);
        chk("fault_start_ctrl", {5'd0, ctrl}, 8'd1);
        do_reset();

        // Program 3 runs normal durations; start mid-program is ignored.
        prog_sel = 2'd3; start = 1'b1; step(); start = 1'b0;
        chk("p3_rem", remaining, 8'd20);
        chk("p3_status", status, 8'h8C);
        step();
        adv(20);
        chk("p3_wash_dur", cmd_dur, 8'd60);
        prog_sel = 2'd0; start = 1'b1; step(); start = 1'b0;
        chk("p3_ign_ctrl", {5'd0, ctrl}, 8'd2);
        chk("p3_ign_rem", remaining, 8'd60);
        chk("p3_ign_status", status, 8'h8C);
        do_reset();

        // Heavy program reset asynchronously mid-SPIN.
        prog_sel = 2'd2; start = 1'b1; step(); start = 1'b0;
        chk("heavy_fill", cmd_dur, 8'd30);
        step(); adv(30);
        step(); adv(120);
        step(); adv(20);
        step(); adv(45);
        chk("heavy_spin_dur", cmd_dur, 8'd90);
        step(); adv(40);
        chk("heavy_rem50", remaining, 8'd50);
        chk("heavy_ctrl", {5'd0, ctrl}, 8'd5);
        #2 rst = 1'b0;
        #1;
        chk_zero("async_rst");
        step();
        rst = 1'b1;
        adv(3);
        chk("post_rst_ctrl", {5'd0, ctrl}, 8'd0);
        chk("post_rst_status", status, 8'h00);
        start = 1'b1; step(); start = 1'b0;
        chk("post_rst_start", {5'd0, ctrl}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/wash_program_sequencer.md
WASH_PROGRAM_SEQUENCER -- requirements
Module: wash_program_sequencer

Interface
REQ-001 Parameter: DONE_HOLD, 5, tick count the DONE phase is held before returning to IDLE (1..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a program.
REQ-005 prog_sel  input  2  program: 0 quick, 1 normal, 2 heavy, 3 treated as normal.
REQ-006 door_closed  input  1  high when the door is latched.
REQ-007 pause_req  input  1  level; high requests a pause.
REQ-008 tick  input  1  one-cycle pulse per time unit (1 s).
REQ-009 cmd_ready  input  1  downstream stage accepts the current command.
REQ-010 ctrl  output  3  phase code: IDLE 0, FILL 1, WASH 2, DRAIN 3, RINSE 4, SPIN 5, DONE 6, PAUSED 7.
REQ-011 cmd_dur  output  8  duration in ticks carried with the command.
REQ-012 cmd_valid  output  1  command offer to the downstream stage.
REQ-013 remaining  output  8  ticks left in the current phase.
REQ-014 status  output  8  bit7 busy, bit6 paused, bit5 done, bit4 door_fault, bits3:2 latched program, bits1:0 zero.

Function
REQ-015 Phase order SHALL be FILL, WASH, DRAIN, RINSE, SPIN, DONE, then IDLE.
REQ-016 Durations in ticks SHALL be: quick 10/30/10/15/20; normal 20/60/15/30/40; heavy 30/120/20/45/90 (FILL/WASH/DRAIN/RINSE/SPIN). DONE uses DONE_HOLD.
REQ-017 IDLE with start=1 and door_closed=1 SHALL latch prog_sel, clear door_fault, and enter FILL on that edge.
REQ-018 IDLE with start=1 and door_closed=0 SHALL set door_fault (sticky) and remain in IDLE.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 On phase entry, remaining SHALL load the phase duration, and cmd_valid=1 SHALL be asserted with cmd_dur=remaining in the same cycle.
REQ-021 ctrl and cmd_dur SHALL stay stable while cmd_valid=1 and cmd_ready=0.
REQ-022 The handshake completes at the edge where cmd_valid and cmd_ready are both 1; cmd_valid SHALL be 0 in the following cycle.
REQ-023 Ticks SHALL be ignored until the handshake completes; afterwards each tick SHALL decrement remaining by 1.
REQ-024 A tick with remaining=1 SHALL advance to the next phase on that edge; the new command is presented in the next cycle (no dead cycle).
REQ-025 In FILL..SPIN, door_closed=0 or pause_req=1 SHALL enter PAUSED on the next edge, saving the phase.
REQ-026 Pause SHALL apply even while cmd_valid=1; the offer is withdrawn. This is the sole permitted withdrawal.
REQ-027 In PAUSED: ctrl=7, cmd_valid=0, remaining frozen, ticks ignored.
REQ-028 Leaving PAUSED requires door_closed=1 and pause_req=0. The block SHALL return to the saved phase and reissue the command with cmd_dur=remaining, without reloading.
REQ-029 The door and pause inputs SHALL be ignored in DONE and IDLE.
REQ-030 When DONE expires, the block SHALL enter IDLE with ctrl=0, remaining=0, and status[5] pulsed high for 1 cycle.
REQ-031 busy SHALL be 1 in every state except IDLE.

Reset
REQ-032 rst low SHALL immediately force IDLE, ctrl=0, cmd_dur=0, cmd_valid=0, remaining=0, status=0, saved phase=IDLE, with no clock required.
REQ-033 Reset asserted mid-phase or mid-handshake SHALL discard the program; a fresh start is required afterwards.

Structure
REQ-034 A shared package wash_pkg SHALL hold the phase-code enum, the duration table constants, and the status bit positions.
REQ-035 A combinational sub-module wash_dur_rom (program x phase -> 8-bit duration) SHALL supply the durations. The FSM and countdown SHALL reside in wash_program_sequencer.

Verification
REQ-036 Quick program, cmd_ready=1, door closed, start: ctrl 1/dur 10, then 2/30, 3/10, 4/15, 5/20, 6/5, then IDLE after 90 ticks total with status[5] pulsed.
REQ-037 Normal program, cmd_ready held 0 for 4 cycles with ticks present: remaining stays 20, ctrl=1 stable; countdown begins after ready.
REQ-038 Normal program, door opened in WASH at remaining=17: ctrl=7, status[6]=1; 3 ticks change nothing; door closed gives ctrl=2, cmd_dur=17, cmd_valid=1.
REQ-039 start with door_closed=0: status[4]=1, ctrl=0; a later valid start clears status[4] and gives ctrl=1.
REQ-040 prog_sel=3 gives normal durations (FILL 20); a start during WASH is ignored.
REQ-041 rst low mid-SPIN (heavy, remaining=50): all outputs 0 asynchronously; after release, ctrl stays 0 until start.
